fetch_queue: RTL and testbench

Parametrised successor to the single-word fetch stage. It walks a flat byte-addressed instruction ROM from an internal PC and buffers {pc, instruction} pairs in a QUEUE_DEPTH-entry FIFO. The FIFO drains to decode over a valid/ready handshake. It accepts a redirect (branch/jump) that flushes the queue and restarts fetch, and it signals completion once the program is exhausted and the queue has drained.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM states and queue entry layout for the fetch queue
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO with wrap-bit pointers and synchronous flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (count_o == '0);
  assign full_o    = (count_o == CW'(DEPTH));
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A full queue may still take a write when the head leaves on the same edge.
  assign do_rd = rd_en_i && !empty_o && !flush_i;
  assign do_wr = wr_en_i && (!full_o || do_rd) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - walks a flat instruction ROM and buffers {pc, instr} pairs for decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          ROM_BYTES   = 1024,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROM_BYTES*8-1:0] instr_rom,
  input  logic [31:0]            rom_size,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [CW-1:0]          queue_count,
  output logic                   fetch_in_progress,
  output logic                   fetch_complete
);

  localparam int              RAW       = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
  localparam logic [XLEN-1:0] ROM_LIMIT = XLEN'(ROM_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] limit;
  logic [XLEN-1:0] byte_addr;
  logic [XLEN-1:0] rom_word;
  logic            enq, flush, deq, can_accept;
  logic            fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    wr_entry, head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign limit = (rom_size < ROM_LIMIT) ? rom_size : ROM_LIMIT;

  // Bytes at or past the limit read as zero, so a straddling word is zero-filled.
  always_comb begin
    rom_word  = '0;
    byte_addr = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      byte_addr = pc_q + XLEN'(k);
      if (byte_addr < limit)
        rom_word[8*k +: 8] = instr_rom[{byte_addr[RAW-1:0], 3'b000} +: 8];
    end
  end

  assign out_valid  = !fifo_empty;
  assign deq        = out_valid && out_ready;
  assign can_accept = !fifo_full || deq;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    enq     = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:  state_d = RUN;
        RUN: begin
          if (pc_q < limit) begin
            if (can_accept) begin
              enq  = 1'b1;
              pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN: if (fifo_empty) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc_q;
    wr_entry.instr = rom_word;
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign out_instr         = out_valid ? head.instr : '0;
  assign out_pc            = out_valid ? head.pc : '0;
  assign queue_count       = fifo_count;
  assign fetch_in_progress = (state_q == RUN) || (state_q == DRAIN);
  assign fetch_complete    = (state_q == DONE);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue against a queue-level model
module tb_fetch_queue;

  localparam int RB = 1024;
  localparam int QD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RB*8-1:0] instr_rom;
  logic [31:0]   rom_size = 32'd16;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [2:0]    queue_count;
  logic          fetch_in_progress;
  logic          fetch_complete;

  always #5 clk = ~clk;

  fetch_queue #(
    .ROM_BYTES   (RB),
    .QUEUE_DEPTH (QD),
    .RESET_PC    (32'h0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_rom         (instr_rom),
    .rom_size          (rom_size),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .queue_count       (queue_count),
    .fetch_in_progress (fetch_in_progress),
    .fetch_complete    (fetch_complete)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic [7:0]  rom_mem [RB];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;
  int          m_st = M_IDLE;

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] lim);
    logic [31:0] w;
    logic [31:0] ad;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ad = a + 32'(k);
      if (ad < lim) w[8*k +: 8] = rom_mem[ad[9:0]];
    end
    return w;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: the queue is just an occupancy plus the scoreboard of entries.
  task automatic model_step();
    logic [31:0] lim;
    bit          deq, can, was_empty;
    exp_t        e;
    if (reset) begin
      m_pc  = 32'h0;
      m_cnt = 0;
      m_st  = M_IDLE;
      sb.delete();
      return;
    end
    lim = (rom_size < 32'(RB)) ? rom_size : 32'(RB);
    deq = (m_cnt > 0) && out_ready;
    if (redirect_valid) begin
      m_cnt = 0;
      sb.delete();
      m_pc  = {redirect_pc[31:2], 2'b00};
      m_st  = M_RUN;
      return;
    end
    was_empty = (m_cnt == 0);
    can = (m_cnt < QD) || deq;
    if (deq) m_cnt--;
    case (m_st)
      M_IDLE: m_st = M_RUN;
      M_RUN: begin
        if (m_pc < lim) begin
          if (can) begin
            e.pc    = m_pc;
            e.instr = ref_word(m_pc, lim);
            sb.push_back(e);
            m_cnt++;
            m_pc = m_pc + 32'd4;
          end
        end else begin
          m_st = M_DRAIN;
        end
      end
      M_DRAIN: if (was_empty) m_st = M_DONE;
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      check32("rst_valid", 32'(out_valid), 32'd0);
      check32("rst_count", 32'(queue_count), 32'd0);
      check32("rst_pc", out_pc, 32'h0);
      check32("rst_instr", out_instr, 32'h0);
      check32("rst_inprog", 32'(fetch_in_progress), 32'd0);
      check32("rst_complete", 32'(fetch_complete), 32'd0);
    end else begin
      check32("count", 32'(queue_count), 32'(m_cnt));
      check32("valid", 32'(out_valid), 32'(m_cnt > 0));
      check32("complete", 32'(fetch_complete), 32'(m_st == M_DONE));
      check32("inprog", 32'(fetch_in_progress), 32'(m_st == M_RUN || m_st == M_DRAIN));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_unexpected: got pc 0x%08h, required no entry at %0t", out_pc, $time);
        end else begin
          check32("head_pc", out_pc, sb[0].pc);
          check32("head_instr", out_instr, sb[0].instr);
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check32("empty_pc", out_pc, 32'h0);
        check32("empty_instr", out_instr, 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int k;
    k = 0;
    while (!fetch_complete && k < budget) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      k++;
    end
    check32("wait_done", 32'(fetch_complete), 32'd1);
  endtask

  task automatic wait_count(input int n, input int budget);
    int k;
    k = 0;
    while (32'(queue_count) != 32'(n) && k < budget) begin
      cyc();
      k++;
    end
    check32("wait_count", 32'(queue_count), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < RB; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) rom_mem[4*i+b] = 8'(8'h11 * (i + 1));
    rom_mem[1020] = 8'hEF;
    rom_mem[1021] = 8'hBE;
    rom_mem[1022] = 8'hAD;
    rom_mem[1023] = 8'hDE;
    for (int i = 0; i < RB; i++) instr_rom[8*i +: 8] = rom_mem[i];

    // Short program, decode always ready.
    rom_size  = 32'd16;
    out_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    wait_done(30, 1'b0);

    // Back-pressure fills the queue, then release.
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    rom_size  = 32'd64;
    out_ready = 1'b0;
    repeat (10) cyc();
    out_ready = 1'b1;
    wait_done(60, 1'b0);

    // Redirect to an unaligned target with three entries queued.
    rom_size  = 32'd1024;
    out_ready = 1'b0;
    redirect(32'h0);
    wait_count(3, 20);
    out_ready = 1'b1;
    redirect(32'h2B);
    repeat (10) cyc();

    // Finish, then restart from DONE.
    rom_size = 32'd16;
    wait_done(60, 1'b0);
    redirect(32'h0);
    wait_done(30, 1'b0);

    // Whole ROM with the limit clamped to ROM_BYTES, then a straddling word.
    rom_size = 32'd2000;
    redirect(32'h0);
    wait_done(3000, 1'b1);
    rom_size  = 32'd1022;
    out_ready = 1'b1;
    redirect(32'd1008);
    wait_done(30, 1'b1);

    // Random traffic with redirects, limit changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 99) == 0) rom_size = 32'($urandom_range(0, 1100));
      reset = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;

    // Reset while three entries are queued.
    rom_size  = 32'd64;
    out_ready = 1'b0;
    redirect(32'h0);
    wait_count(3, 20);
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    out_ready = 1'b1;
    wait_done(60, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
